// File: rtl/serial_to_parallel_pkg.sv
// Shared types for the serial_to_parallel deserializer.
package serial_to_parallel_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } stp_state_e;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Word-in / frame-out handshake bundle for serial_to_parallel.
interface serial_to_parallel_if #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) ();

  logic [BIT_WIDTH-1:0]           recv_msg;
  logic                           recv_val;
  logic                           recv_rdy;
  logic                           flush;
  logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg;
  logic [CNT_W-1:0]               send_count;
  logic                           send_val;
  logic                           send_rdy;

  modport master (
    output recv_msg, recv_val, flush, send_rdy,
    input  recv_rdy, send_msg, send_count, send_val
  );

  modport slave (
    input  recv_msg, recv_val, flush, send_rdy,
    output recv_rdy, send_msg, send_count, send_val
  );

endinterface

// File: rtl/serial_to_parallel_ctrl.sv
// FILL/FULL sequencer: write index, slot write enables, slot clear and
// the registered output-side status (recv_rdy, send_val, send_count).
module serial_to_parallel_ctrl
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  input  logic                 flush,
  input  logic                 send_rdy,
  output logic                 recv_rdy,
  output logic                 send_val,
  output logic [CNT_W-1:0]     send_count,
  output logic [N_SAMPLES-1:0] wr_en_c,
  output logic                 slot_clr_c
);

  stp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rdy_q, rdy_d;
  logic             val_q, val_d;
  logic             acc_c, snd_c, last_c;
  logic [CNT_W-1:0] eff_c;

  // rdy_q is only ever high in FILL, so it alone qualifies an input handshake
  assign acc_c  = recv_val & rdy_q;
  assign snd_c  = val_q & send_rdy;
  assign eff_c  = cnt_q + CNT_W'(acc_c);
  assign last_c = acc_c && (cnt_q == CNT_W'(N_SAMPLES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    slot_clr_c = 1'b0;
    case (state_q)
      FILL: begin
        if (acc_c) cnt_d = eff_c;
        if (last_c || (flush && (eff_c != '0))) begin
          state_d = FULL;
          count_d = eff_c;
        end
      end
      FULL: begin
        if (snd_c) begin
          state_d    = FILL;
          cnt_d      = '0;
          count_d    = '0;
          slot_clr_c = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    rdy_d = (state_d == FILL);
    val_d = (state_d == FULL);
  end

  always_comb begin
    wr_en_c = '0;
    for (int i = 0; i < int'(N_SAMPLES); i++) begin
      wr_en_c[i] = acc_c && (cnt_q == CNT_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
    end
  end

  assign recv_rdy   = rdy_q;
  assign send_val   = val_q;
  assign send_count = count_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer: collects N_SAMPLES words into one frame presented on val/rdy,
// with early flush of partial frames and a valid-slot count.
module serial_to_parallel #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_to_parallel_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(N_SAMPLES + 1);
  localparam int unsigned FRAME_W = N_SAMPLES * BIT_WIDTH;

  logic [N_SAMPLES-1:0] wr_en_c;
  logic                 slot_clr_c;
  logic [FRAME_W-1:0]   frame_c;

  serial_to_parallel_ctrl #(
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .recv_val   (bus.recv_val),
    .flush      (bus.flush),
    .send_rdy   (bus.send_rdy),
    .recv_rdy   (bus.recv_rdy),
    .send_val   (bus.send_val),
    .send_count (bus.send_count),
    .wr_en_c    (wr_en_c),
    .slot_clr_c (slot_clr_c)
  );

  // Clear on send wins; write and clear never coincide since writes need FILL
  for (genvar i = 0; i < int'(N_SAMPLES); i++) begin : g_slot
    logic [BIT_WIDTH-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (slot_clr_c)      slot_d = '0;
      else if (wr_en_c[i]) slot_d = bus.recv_msg;
    end

    always_ff @(posedge clk) begin
      if (reset) slot_q <= '0;
      else       slot_q <= slot_d;
    end

    assign frame_c[i*BIT_WIDTH +: BIT_WIDTH] = slot_q;
  end

  assign bus.send_msg = frame_c;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed vector table on an 8x4 instance plus random-handshake
// scoreboards on 32x2 and 32x16 instances.
module tb_serial_to_parallel;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_to_parallel_if #(.BIT_WIDTH(8),  .N_SAMPLES(4))  b4  ();
  serial_to_parallel_if #(.BIT_WIDTH(32), .N_SAMPLES(2))  b2  ();
  serial_to_parallel_if #(.BIT_WIDTH(32), .N_SAMPLES(16)) b16 ();

  serial_to_parallel #(.BIT_WIDTH(8),  .N_SAMPLES(4))  u4  (.clk(clk), .reset(rst), .bus(b4));
  serial_to_parallel #(.BIT_WIDTH(32), .N_SAMPLES(2))  u2  (.clk(clk), .reset(rst), .bus(b2));
  serial_to_parallel #(.BIT_WIDTH(32), .N_SAMPLES(16)) u16 (.clk(clk), .reset(rst), .bus(b16));

  typedef struct packed {
    logic        v;
    logic [7:0]  m;
    logic        f;
    logic        sr;
    logic        er;
    logic        ev;
    logic [31:0] em;
    logic [2:0]  ec;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic vec(input logic v, input logic [7:0] m, input logic f, input logic sr,
                     input logic er, input logic ev, input logic [31:0] em, input logic [2:0] ec);
    vec_t t;
    t.v = v; t.m = m; t.f = f; t.sr = sr; t.er = er; t.ev = ev; t.em = em; t.ec = ec;
    tv.push_back(t);
  endtask

  task automatic drive4(input logic v, input logic [7:0] m, input logic f, input logic sr);
    b4.recv_val = v; b4.recv_msg = m; b4.flush = f; b4.send_rdy = sr;
  endtask

  task automatic chk4(input string nm, input logic er, input logic ev,
                      input logic [31:0] em, input logic [2:0] ec);
    check({nm, "_rdy"}, 64'(b4.recv_rdy),   64'(er));
    check({nm, "_val"}, 64'(b4.send_val),   64'(ev));
    check({nm, "_msg"}, 64'(b4.send_msg),   64'(em));
    check({nm, "_cnt"}, 64'(b4.send_count), 64'(ec));
  endtask

  function automatic logic [31:0] wd(input int k);
    return 32'(k) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  initial begin
    rst = 1'b1;
    drive4(1'b0, 8'h00, 1'b0, 1'b0);
    b2.recv_val = 1'b0;  b2.recv_msg = '0;  b2.flush = 1'b0;  b2.send_rdy = 1'b0;
    b16.recv_val = 1'b0; b16.recv_msg = '0; b16.flush = 1'b0; b16.send_rdy = 1'b0;

    //   val  msg    fl    srdy  | rdy  sval  msg           cnt
    vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000000, 3'd0);
    vec(1'b1, 8'h22, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000011, 3'd0);
    vec(1'b1, 8'h33, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00002211, 3'd0);
    vec(1'b1, 8'h44, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00332211, 3'd0);
    vec(1'b1, 8'h55, 1'b0, 1'b1,  1'b0, 1'b1, 32'h44332211, 3'd4);
    vec(1'b0, 8'h00, 1'b1, 1'b1,  1'b1, 1'b0, 32'h00000000, 3'd0);
    vec(1'b1, 8'hAA, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000000, 3'd0);
    vec(1'b1, 8'hBB, 1'b0, 1'b1,  1'b1, 1'b0, 32'h000000AA, 3'd0);
    vec(1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 1'b0, 32'h0000BBAA, 3'd0);
    vec(1'b1, 8'hEE, 1'b1, 1'b0,  1'b0, 1'b1, 32'h0000BBAA, 3'd2);
    vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h0000BBAA, 3'd2);
    vec(1'b1, 8'hAA, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000000, 3'd0);
    vec(1'b1, 8'hBB, 1'b0, 1'b1,  1'b1, 1'b0, 32'h000000AA, 3'd0);
    vec(1'b1, 8'hCC, 1'b1, 1'b0,  1'b1, 1'b0, 32'h0000BBAA, 3'd0);
    vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h00CCBBAA, 3'd3);
    vec(1'b1, 8'h01, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000000, 3'd0);
    vec(1'b1, 8'h02, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000001, 3'd0);
    vec(1'b1, 8'h03, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000201, 3'd0);
    vec(1'b1, 8'h04, 1'b1, 1'b1,  1'b1, 1'b0, 32'h00030201, 3'd0);
    vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h04030201, 3'd4);
    vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00000000, 3'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk4("reset", 1'b0, 1'b0, 32'h0, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_rdy", 64'(b4.recv_rdy), 64'd1);

    foreach (tv[i]) begin
      chk4($sformatf("v%0d", i), tv[i].er, tv[i].ev, tv[i].em, tv[i].ec);
      drive4(tv[i].v, tv[i].m, tv[i].f, tv[i].sr);
      @(negedge clk);
    end

    // Backpressure: complete a frame, then hold send_rdy low for 10 cycles
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 8'(8'hD1 + i), 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      drive4(1'b1, 8'h99, 1'b0, 1'b0);
      chk4($sformatf("stall%0d", i), 1'b0, 1'b1, 32'hD4D3D2D1, 3'd4);
      @(negedge clk);
    end
    drive4(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive4(1'b0, 8'h00, 1'b0, 1'b0);
    chk4("stall_release", 1'b1, 1'b0, 32'h0, 3'd0);

    // Reset with a partial frame held
    drive4(1'b1, 8'h61, 1'b0, 1'b0); @(negedge clk);
    drive4(1'b1, 8'h62, 1'b0, 1'b0); @(negedge clk);
    drive4(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1; @(negedge clk);
    chk4("rst_partial", 1'b0, 1'b0, 32'h0, 3'd0);
    rst = 1'b0; @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
      @(negedge clk);
    end
    drive4(1'b0, 8'h00, 1'b0, 1'b0);
    chk4("post_rst_frame", 1'b0, 1'b1, 32'h74737271, 3'd4);

    // Reset while FULL, then a short flushed frame
    rst = 1'b1; @(negedge clk);
    chk4("rst_full", 1'b0, 1'b0, 32'h0, 3'd0);
    rst = 1'b0; @(negedge clk);
    drive4(1'b1, 8'h81, 1'b0, 1'b0); @(negedge clk);
    drive4(1'b1, 8'h82, 1'b1, 1'b0); @(negedge clk);
    drive4(1'b0, 8'h00, 1'b0, 1'b0);
    chk4("rst_full_next", 1'b0, 1'b1, 32'h00008281, 3'd2);
    drive4(1'b0, 8'h00, 1'b0, 1'b1); @(negedge clk);
    drive4(1'b0, 8'h00, 1'b0, 1'b0);

    fork
      begin : sweep2
        int  k, fk, frames;
        logic pend;
        k = 0; fk = 0; frames = 0; pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
          @(negedge clk);
          if (pend) k++;
          b2.recv_val = ($urandom_range(0, 3) != 0);
          b2.recv_msg = wd(k);
          pend = b2.recv_val & b2.recv_rdy;
          b2.send_rdy = ($urandom_range(0, 2) != 0);
          if (b2.send_val && b2.send_rdy) begin
            for (int i = 0; i < 2; i++)
              check($sformatf("sw2_f%0d_s%0d", frames, i), 64'(b2.send_msg[i*32 +: 32]), 64'(wd(fk + i)));
            check("sw2_cnt", 64'(b2.send_count), 64'd2);
            fk += 2;
            frames++;
          end
        end
        check("sw2_progress", 64'(frames > 50), 64'd1);
      end
      begin : sweep16
        int  k, fk, frames;
        logic pend;
        k = 1000; fk = 1000; frames = 0; pend = 1'b0;
        for (int c = 0; c < 1500; c++) begin
          @(negedge clk);
          if (pend) k++;
          b16.recv_val = ($urandom_range(0, 3) != 0);
          b16.recv_msg = wd(k);
          pend = b16.recv_val & b16.recv_rdy;
          b16.send_rdy = ($urandom_range(0, 2) != 0);
          if (b16.send_val && b16.send_rdy) begin
            for (int i = 0; i < 16; i++)
              check($sformatf("sw16_f%0d_s%0d", frames, i), 64'(b16.send_msg[i*32 +: 32]), 64'(wd(fk + i)));
            check("sw16_cnt", 64'(b16.send_count), 64'd16);
            fk += 16;
            frames++;
          end
        end
        check("sw16_progress", 64'(frames > 20), 64'd1);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Parametrised deserializer that collects `N_SAMPLES` words of `BIT_WIDTH` bits, arriving one per handshake, and presents them as one wide frame on a val/rdy output. It generalises the fixed two-register parallel block to any depth. It adds output backpressure, an early-flush mode for partial frames and an occupancy count. It sits between a sample-producing stage (e.g. an ADC/SPI front end) and the frame-consuming FFT/classifier datapath.

## Interface
Parameters:
- `BIT_WIDTH`, 32: width of one input word.
- `N_SAMPLES`, 8: words per frame. Must be ≥ 2.
- `CNT_W`, `$clog2(N_SAMPLES+1)`: derived width of the count. Not to be overridden.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `recv_msg`  in  `BIT_WIDTH`: incoming word.
- `recv_val`  in  1: producer has a valid word.
- `recv_rdy`  out  1: block accepts a word this cycle.
- `flush`  in  1: request early emission of a partial frame.
- `send_msg`  out  `N_SAMPLES*BIT_WIDTH`: frame. Slot i occupies bits [(i+1)*BIT_WIDTH-1 : i*BIT_WIDTH]. Slot 0 is the first word received.
- `send_count`  out  `CNT_W`: number of valid slots in the frame, from 1 to `N_SAMPLES`.
- `send_val`  out  1: frame valid.
- `send_rdy`  in  1: consumer accepts the frame.

## Operation
- The FSM has two states: FILL and FULL.
  - Reset state is FILL.
  - Reset clears every slot to 0 and the write index `cnt` to 0.
- **FILL state**
  - `recv_rdy` = 1.
  - `send_val` = 0.
  - `send_count` = 0.
- **Accepting a word** (FILL, `recv_val` = 1)
  - `recv_msg` is written to slot `cnt`.
  - `cnt` increments.
  - If `cnt` was `N_SAMPLES-1`, the next state is FULL and the frame count is `N_SAMPLES`.
- **Flush**
  - `flush` is sampled only in FILL.
  - Let the effective count be `cnt`, plus 1 if a word is accepted in the same cycle.
  - If the effective count is > 0, the next state is FULL and the frame count equals the effective count.
  - If the effective count is 0, `flush` is ignored.
  - `flush` together with acceptance of the last word gives a normal full frame with count `N_SAMPLES`.
- **FULL state**
  - `recv_rdy` = 0.
  - `send_val` = 1.
  - `send_msg` and `send_count` are held stable until the output handshake.
  - `flush` is ignored.
- **Leaving FULL**: the output handshake is `send_val` & `send_rdy`. In that cycle:
  - the next state is FILL;
  - `cnt` is set to 0;
  - every slot is cleared to 0.
  - Unused slots of a later partial frame therefore read 0.
- No input is accepted in the cycle the frame is sent. Steady-state throughput is one frame per `N_SAMPLES+1` cycles when both sides are always ready.
- `recv_msg` is ignored whenever no input handshake occurs.

## Timing
- Latency: `send_val` rises on the clock edge that captures the last word (or that samples `flush`). The frame is visible the following cycle.
- `recv_rdy` and `send_val` are Moore outputs, decoded from the state only. Neither depends combinationally on `recv_val` or `send_rdy`.
- **Reset**
  - While `reset` = 1: `recv_rdy` = 0, `send_val` = 0, `send_count` = 0, `send_msg` = 0.
  - First cycle after reset is released: `recv_rdy` = 1.
- **Reset during operation**: from any state, with any partial or held frame, `reset` discards all contents. No frame is emitted.
- **Consumer stall**: `send_rdy` may stay low indefinitely. Output holds, and the input stays stalled with `recv_rdy` = 0.
- **Wrap**: `cnt` never exceeds `N_SAMPLES-1` in FILL. FULL is entered exactly when the slot `N_SAMPLES-1` write occurs.

## Structure
- Shared package `serial_to_parallel_pkg` holds the state typedef (FILL/FULL enum).
- One sub-module, `serial_to_parallel_ctrl`, contains the FSM and `cnt` counter. It produces:
  - per-slot write enables (one-hot decode of `cnt`, gated by the input handshake);
  - slot clear, `recv_rdy`, `send_val` and the registered `send_count`.
- The top level holds `N_SAMPLES` `BIT_WIDTH`-bit slot registers, built with a generate loop, and flattens them onto `send_msg`.

## Test plan
All scenarios use `BIT_WIDTH`=8 and `N_SAMPLES`=4 unless stated.
- **Full frame**: after reset, feed 0x11, 0x22, 0x33, 0x44 back-to-back with `send_rdy`=1 → `send_msg`=0x44332211, `send_count`=4, and `send_val` high for exactly one cycle, one cycle after the 0x44 accept. Next frame accepted the cycle after.
- **Backpressure**: complete a frame with `send_rdy`=0 for 10 cycles → `recv_rdy`=0 and `send_msg` stable throughout. Raising `send_rdy` gives one handshake, then `recv_rdy`=1.
- **Partial flush**: feed 0xAA, 0xBB, then pulse `flush` alone → `send_msg`=0x0000BBAA, `send_count`=2. A flush in the same cycle as a 3rd word 0xCC → 0x00CCBBAA, `send_count`=3.
- **Ignored flush**:
  - `flush` with `cnt`=0 and no word → no `send_val`.
  - `flush` during FULL → frame and count unchanged.
- **Reset during operation**: assert `reset` after 2 words, and again while FULL → outputs 0, `send_val`=0, and the next frame contains only post-reset words.
- **Parameter sweep**: `N_SAMPLES`=2 and 16, `BIT_WIDTH`=32, with random `recv_val`/`send_rdy` → every frame matches a scoreboard of in-order words. No word is lost or duplicated.
